vector_mem_seq: RTL and testbench

VECTOR_MEM_SEQ -- requirements
Module: vector_mem_seq

---
 rtl/cvp14_pkg.sv | 9 +
 rtl/vseq_lat_pipe.sv | 31 +++
 rtl/vector_mem_seq.sv | 73 +++++++
 tb/tb_vector_mem_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cvp14_pkg.sv
// cvp14_pkg: shared vector-memory sizes, sequencer states and opcodes
package cvp14_pkg;
  localparam int VLEN = 16;
  localparam int DW = 16;
  localparam int AW = 16;
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, STORE, DONE} state_t;
  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_STORE = 1'b1;
endpackage

// File: rtl/vseq_lat_pipe.sv
// vseq_lat_pipe: MEM_LAT-deep valid/index delay line tracking reads in flight
module vseq_lat_pipe #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_idx,
  output logic       out_valid,
  output logic [3:0] out_idx,
  output logic       pending
);
  localparam int IW = 4 * MEM_LAT;
  logic [MEM_LAT-1:0] v, v_nxt;
  logic [MEM_LAT-1:0][3:0] ix, ix_nxt;
  assign v_nxt = MEM_LAT'({v, in_valid});
  assign ix_nxt = IW'({ix, in_idx});
  assign out_valid = v[MEM_LAT-1];
  assign out_idx = ix[MEM_LAT-1];
  // reads still travelling behind the one currently leaving the line
  assign pending = |v_nxt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
      ix <= '0;
    end else begin
      v <= v_nxt;
      ix <= ix_nxt;
    end
  end
endmodule

// File: rtl/vector_mem_seq.sv
// vector_mem_seq: strided vector load/store sequencer between DRAM and the VRF
module vector_mem_seq
  import cvp14_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic          Clk1,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Op,
  input  logic [AW-1:0] BaseAddr,
  input  logic [AW-1:0] Stride,
  input  logic [2:0]    VReg,
  output logic          Busy,
  output logic          Done,
  output logic [AW-1:0] Addr,
  output logic          RD,
  output logic          WR,
  output logic [DW-1:0] DataOut,
  input  logic [DW-1:0] DataIn,
  output logic [2:0]    vAddr,
  output logic [3:0]    vElem,
  output logic          vWrEn,
  output logic [DW-1:0] vWrData,
  input  logic [DW-1:0] vRdData
);
  state_t state;
  logic [AW-1:0] addr, stride;
  logic [2:0] vreg;
  logic [3:0] cnt, pix;
  logic pv, pend, last;
  assign last = cnt == 4'(VLEN - 1);
  vseq_lat_pipe #(.MEM_LAT(MEM_LAT)) u_pipe (
    .clk(Clk1), .rst_n(Reset), .in_valid(RD), .in_idx(cnt),
    .out_valid(pv), .out_idx(pix), .pending(pend)
  );
  always_ff @(posedge Clk1) begin
    if (!Reset) begin
      state <= IDLE;
      addr <= '0;
      stride <= '0;
      vreg <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          state <= Op == OP_STORE ? STORE : LOAD;
          addr <= BaseAddr;
          stride <= Stride;
          vreg <= VReg;
          cnt <= '0;
        end
        LOAD, STORE: begin
          addr <= addr + stride;
          cnt <= cnt + 4'd1;
          if (last) state <= state == LOAD ? DRAIN : DONE;
        end
        DRAIN: if (!pend) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
  assign RD = state == LOAD;
  assign WR = state == STORE;
  assign Busy = state != IDLE;
  assign Done = state == DONE;
  assign Addr = RD | WR ? addr : '0;
  assign DataOut = WR ? vRdData : '0;
  assign vWrEn = pv;
  assign vWrData = pv ? DataIn : '0;
  assign vAddr = WR | pv ? vreg : '0;
  assign vElem = WR ? cnt : pv ? pix : '0;
endmodule

// File: tb/tb_vector_mem_seq.sv
// tb_vector_mem_seq: scoreboard bench driving MEM_LAT=1 and MEM_LAT=3 instances in lockstep
module tb_vector_mem_seq;
  logic clk, rst_n, start, op;
  logic [15:0] base, stride;
  logic [2:0] vreg;
  logic busy [2], done [2], rd [2], wr [2], vwe [2];
  logic [15:0] addr [2], dout [2], din [2], vwd [2], vrd [2];
  logic [2:0] vaddr [2];
  logic [3:0] velem [2];
  logic [15:0] dram [2][65536];
  logic [15:0] vrf [2][8][16];
  logic [15:0] p1, p3 [3];
  logic [32:0] rq [2][$];
  logic [32:0] wq [2][$];
  int dq [2][$];
  int cyc = 0;
  int n_assert = 0, n_fail = 0;

  vector_mem_seq #(.MEM_LAT(1)) u0 (
    .Clk1(clk), .Reset(rst_n), .Start(start), .Op(op), .BaseAddr(base), .Stride(stride),
    .VReg(vreg), .Busy(busy[0]), .Done(done[0]), .Addr(addr[0]), .RD(rd[0]), .WR(wr[0]),
    .DataOut(dout[0]), .DataIn(din[0]), .vAddr(vaddr[0]), .vElem(velem[0]),
    .vWrEn(vwe[0]), .vWrData(vwd[0]), .vRdData(vrd[0])
  );
  vector_mem_seq #(.MEM_LAT(3)) u1 (
    .Clk1(clk), .Reset(rst_n), .Start(start), .Op(op), .BaseAddr(base), .Stride(stride),
    .VReg(vreg), .Busy(busy[1]), .Done(done[1]), .Addr(addr[1]), .RD(rd[1]), .WR(wr[1]),
    .DataOut(dout[1]), .DataIn(din[1]), .vAddr(vaddr[1]), .vElem(velem[1]),
    .vWrEn(vwe[1]), .vWrData(vwd[1]), .vRdData(vrd[1])
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  assign din[0] = p1;
  assign din[1] = p3[2];
  assign vrd[0] = vrf[0][vaddr[0]][velem[0]];
  assign vrd[1] = vrf[1][vaddr[1]][velem[1]];

  // DRAM / VRF models; DRAM word a holds a+0x9F00 so DRAM[0x100+i] = 0xA000+i
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int k = 0; k < 2; k++) begin
        for (int a = 0; a < 65536; a++) dram[k][a] = 16'(a) + 16'h9F00;
        for (int r = 0; r < 8; r++)
          for (int e = 0; e < 16; e++) vrf[k][r][e] = r == 2 ? 16'h5500 + 16'(e) : 16'h1111;
      end
      p1 = '0;
      for (int j = 0; j < 3; j++) p3[j] = '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr[k]) dram[k][addr[k]] = dout[k];
        if (vwe[k]) vrf[k][vaddr[k]][velem[k]] = vwd[k];
      end
      p1 = rd[0] ? dram[0][addr[0]] : '0;
      p3[2] = p3[1];
      p3[1] = p3[0];
      p3[0] = rd[1] ? dram[1][addr[1]] : '0;
    end
    cyc = cyc + 1;
  end

  function automatic int lat(input int k);
    return k != 0 ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [32:0] e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rd[k]) begin
          if (rq[k].size() == 0) chk("rd_unexpected", 1, 0);
          else begin
            e = rq[k].pop_front();
            chk("rd_addr", 33'(addr[k]), e);
          end
        end
        if (wr[k] || vwe[k]) begin
          if (wq[k].size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            e = wq[k].pop_front();
            chk("write", wr[k] ? {1'b1, addr[k], dout[k]} : {1'b0, 9'd0, vaddr[k], velem[k], vwd[k]}, e);
          end
        end
        if (done[k]) begin
          if (dq[k].size() == 0) chk("done_unexpected", 1, 0);
          else chk("done_cycle", 33'(cyc), 33'(dq[k].pop_front()));
        end
        chk("rd_wr_excl", 33'(rd[k] & wr[k]), 0);
        if (!busy[k] || done[k]) chk("idle_quiet", 33'({rd[k], wr[k], vwe[k]}), 0);
        if (!(rd[k] || wr[k])) chk("addr_idle0", 33'(addr[k]), 0);
        if (!wr[k]) chk("dout_idle0", 33'(dout[k]), 0);
        if (!vwe[k]) chk("vwd_idle0", 33'(vwd[k]), 0);
      end
    end
  endtask

  task automatic push(input logic o, input logic [15:0] b, input logic [15:0] s,
                      input logic [2:0] r, input int t0);
    logic [15:0] a;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        a = b + s * 16'(i);
        if (!o) begin
          rq[k].push_back(33'(a));
          wq[k].push_back({1'b0, 9'd0, r, 4'(i), dram[k][a]});
        end else wq[k].push_back({1'b1, a, vrf[k][r][i]});
      end
      dq[k].push_back(t0 + 17 + (o ? 0 : lat(k)));
    end
  endtask

  task automatic go(input logic o, input logic [15:0] b, input logic [15:0] s, input logic [2:0] r);
    op = o;
    base = b;
    stride = s;
    vreg = r;
    start = 1;
    push(o, b, s, r, cyc);
  endtask

  task automatic req(input logic o, input logic [15:0] b, input logic [15:0] s, input logic [2:0] r);
    go(o, b, s, r);
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((dq[0].size() != 0 || dq[1].size() != 0 || busy[0] || busy[1]) && n < 120) begin
      @(posedge clk);
      #1 n++;
    end
    chk("idle_timeout", 33'(n < 120), 1);
  endtask

  initial begin
    int t;
    rst_n = 0;
    start = 0;
    op = 0;
    base = '0;
    stride = '0;
    vreg = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ctrl", 33'({busy[k], done[k], rd[k], wr[k], vwe[k], vaddr[k], velem[k]}), 0);
      chk("rst_data", 33'({addr[k] | dout[k] | vwd[k]}), 0);
    end
    rst_n = 1;
    fork monitor(); join_none
    @(posedge clk);
    #1;
    req(0, 16'h0100, 16'd1, 3'd4);
    wait_idle();
    for (int k = 0; k < 2; k++) begin
      chk("load_v4_0", 33'(vrf[k][4][0]), 33'h0A000);
      chk("load_v4_15", 33'(vrf[k][4][15]), 33'h0A00F);
    end
    req(1, 16'hFFFE, 16'd1, 3'd2);
    wait_idle();
    for (int k = 0; k < 2; k++) begin
      chk("store_fffe", 33'(dram[k][16'hFFFE]), 33'h05500);
      chk("store_ffff", 33'(dram[k][16'hFFFF]), 33'h05501);
      chk("store_000d", 33'(dram[k][16'h000D]), 33'h0550F);
    end
    req(0, 16'h0040, 16'd0, 3'd1);
    wait_idle();
    for (int k = 0; k < 2; k++) chk("stride0_v1_15", 33'(vrf[k][1][15]), 33'h09F40);
    req(0, 16'h0300, 16'd3, 3'd5);
    repeat (4) @(posedge clk);
    #1;
    op = 1;
    base = 16'h0800;
    stride = 16'd7;
    vreg = 3'd3;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_idle();
    for (int k = 0; k < 2; k++) chk("ignored_dram800", 33'(dram[k][16'h0800]), 33'h0A700);
    t = cyc;
    go(1, 16'h0500, 16'd2, 3'd2);
    @(posedge clk);
    #1;
    op = 0;
    base = 16'h0600;
    stride = 16'd1;
    vreg = 3'd7;
    push(0, 16'h0600, 16'd1, 3'd7, t + 18);
    repeat (18) @(posedge clk);
    #1 start = 0;
    wait_idle();
    for (int k = 0; k < 2; k++) chk("b2b_v7_3", 33'(vrf[k][7][3]), 33'h0A503);
    req(0, 16'h0200, 16'd1, 3'd6);
    repeat (7) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      rq[k].delete();
      wq[k].delete();
      dq[k].delete();
      chk("abort_quiet", 33'({busy[k], rd[k], wr[k], vwe[k]}), 0);
    end
    rst_n = 1;
    repeat (30) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      for (int e = 8; e < 16; e++) chk("abort_v6_keep", 33'(vrf[k][6][e]), 33'h01111);
    chk("abort_v6_0", 33'(vrf[1][6][0]), 33'h0A100);
    for (int k = 0; k < 2; k++) chk("sb_empty", 33'(rq[k].size() + wq[k].size() + dq[k].size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
